// File: rtl/seq_div_unit.sv
// seq_div_unit: iterative restoring divider, 2*width-bit dividend by width-bit divisor,
// valid/ready on both sides. Optional DIV_BACK2BACK_EN accepts a new operation on the result-consume edge.
module seq_div_unit #(
  parameter int width = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*width-1:0] dividend,
  input  logic [width-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [width-1:0]   quotient,
  output logic [width-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = (width > 1) ? $clog2(width) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [width-1:0] r_div;
  logic [width-1:0] r_part;
  logic [width-1:0] r_shq;
  logic [CW-1:0]    r_count;
  logic [width-1:0] r_quot;
  logic [width-1:0] r_rem;
  logic             r_dz;
  logic             r_ov;

  logic             w_accept;
  logic             w_in_ready;
  logic [width-1:0] w_hi;
  logic [width-1:0] w_lo;
  logic             w_err;
  logic             w_last;
  logic [width:0]   w_trial;
  logic             w_ge;
  logic [width-1:0] w_part_next;
  logic [width-1:0] w_shq_next;

  assign w_hi = dividend[2*width-1:width];
  assign w_lo = dividend[width-1:0];
  // The high half must be strictly below the divisor, otherwise the quotient needs more than width bits.
  assign w_err  = (divisor == '0) || (w_hi >= divisor);
  assign w_last = (r_count == CW'(width - 1));

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign w_trial     = {r_part, r_shq[width-1]};
  assign w_ge        = (w_trial >= {1'b0, r_div});
  assign w_part_next = w_ge ? (w_trial[width-1:0] - r_div) : w_trial[width-1:0];
  assign w_shq_next  = {r_shq[width-2:0], w_ge};

  // State register; in_ready and out_valid are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == S_IDLE);
      r_out_valid <= (w_state_next == S_DONE);
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves w_state_next unassigned and infers a latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_err ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_accept)       w_state_next = w_err ? S_DONE : S_CALC;
        else if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
`ifdef DIV_BACK2BACK_EN
    w_in_ready = r_in_ready | ((r_state == S_DONE) & out_ready);
`else
    w_in_ready = r_in_ready;
`endif
    w_accept = in_valid & w_in_ready;
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dz;
  assign overflow    = r_ov;

  // Datapath: operand capture, iteration, and result registers held until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are plain flops, not a memory, so they are cleared by the async reset like the FSM.
      r_div   <= '0;
      r_part  <= '0;
      r_shq   <= '0;
      r_count <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dz    <= 1'b0;
      r_ov    <= 1'b0;
    end else if (w_accept) begin
      r_div   <= divisor;
      r_part  <= w_hi;
      r_shq   <= w_lo;
      r_count <= '0;
      r_dz    <= 1'b0;
      r_ov    <= 1'b0;
      if (divisor == '0) begin
        r_quot <= '1;
        r_rem  <= w_lo;
        r_dz   <= 1'b1;
      end else if (w_hi >= divisor) begin
        r_quot <= '1;
        r_rem  <= '0;
        r_ov   <= 1'b1;
      end
    end else if (r_state == S_CALC) begin
      r_part  <= w_part_next;
      r_shq   <= w_shq_next;
      r_count <= r_count + CW'(1);
      if (w_last) begin
        r_quot <= w_shq_next;
        r_rem  <= w_part_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: directed plan cases plus randomized operations
// compared against an arithmetic reference model.
module tb_seq_div_unit;

  localparam int W    = 6;
  localparam int QMAX = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  int n_cmp = 0;
  int n_err = 0;

  seq_div_unit #(.width(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division with the error rules applied on the true quotient.
  function automatic void ref_div(input int dd, input int ds, output int q, output int r,
                                  output int dz, output int ov);
    dz = 0;
    ov = 0;
    if (ds == 0) begin
      q  = QMAX;
      r  = dd % (QMAX + 1);
      dz = 1;
    end else if (dd / ds > QMAX) begin
      q  = QMAX;
      r  = 0;
      ov = 1;
    end else begin
      q = dd / ds;
      r = dd % ds;
    end
  endfunction

  task automatic wait_out_valid(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 50) begin
      tick();
      cnt++;
    end
  endtask

  task automatic run_op(input int dd, input int ds, input int stall);
    int q, r, dz, ov, lat, cnt, exp_rdy;
    ref_div(dd, ds, q, r, dz, ov);
    lat = (dz != 0 || ov != 0) ? 0 : W;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid  = 1'b1;
    dividend  = (2*W)'(dd);
    divisor   = W'(ds);
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    dividend = (2*W)'($urandom);
    divisor  = W'($urandom);
    wait_out_valid(cnt);
    check("latency", cnt, lat);
    check("quotient", quotient, q);
    check("remainder", remainder, r);
    check("div_by_zero", div_by_zero, dz);
    check("overflow", overflow, ov);
`ifdef DIV_BACK2BACK_EN
    exp_rdy = out_ready;
`else
    exp_rdy = 0;
`endif
    check("in_ready_done", in_ready, exp_rdy);
    for (int i = 0; i < stall; i++) begin
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_quotient", quotient, q);
      check("hold_remainder", remainder, r);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consumed_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_quotient_held", quotient, q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    // Reset state
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_flags", {div_by_zero, overflow}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_release_in_ready", in_ready, 0);
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Directed plan cases and boundaries
    run_op(100, 7, 0);
    run_op(4031, 63, 0);
    run_op(4032, 63, 0);
    run_op(50, 0, 0);
    run_op(4095, 0, 1);
    run_op(63, 1, 0);
    run_op(64, 1, 0);
    run_op(0, 1, 0);
    run_op(62, 63, 2);

    // Backpressure: result held while out_ready is low
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    in_valid  = 1'b1;
    dividend  = 12'd100;
    divisor   = 6'd7;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out_valid(cnt);
    check("bp_latency", cnt, W);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_quotient", quotient, 14);
      check("bp_remainder", remainder, 2);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
`ifdef DIV_BACK2BACK_EN
    in_valid = 1'b1;
    dividend = 12'd60;
    divisor  = 6'd5;
    #1;
    check("b2b_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("b2b_valid_drop", out_valid, 0);
    wait_out_valid(cnt);
    check("b2b_latency", cnt, W);
    check("b2b_quotient", quotient, 12);
    check("b2b_remainder", remainder, 0);
    check("b2b_flags", {div_by_zero, overflow}, 0);
    tick();
    check("b2b_consumed", out_valid, 0);
`else
    tick();
    check("bp_consumed", out_valid, 0);
    check("bp_idle_ready", in_ready, 1);
`endif
    out_ready = 1'b0;
    tick();

    // Reset in the middle of an iteration
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    in_valid  = 1'b1;
    dividend  = 12'd100;
    divisor   = 6'd7;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_flags", {div_by_zero, overflow}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_release_ready", in_ready, 1);
    check("mid_rst_no_result", out_valid, 0);
    run_op(9, 2, 0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      int mode, ds, hi, lo, dd;
      mode = $urandom_range(0, 7);
      ds   = $urandom_range(1, QMAX);
      hi   = $urandom_range(0, ds - 1);
      lo   = $urandom_range(0, QMAX);
      if (mode == 1) hi = $urandom_range(ds, QMAX);
      dd = hi * (QMAX + 1) + lo;
      if (mode == 0) ds = 0;
      run_op(dd, ds, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
